// File: rtl/lo_nco_quad.sv
// Phase-accumulator quadrature LO producing square or three-level sign/zero streams for channel mixers.
// Outputs registered one cycle after the accumulator value; tuning words are applied only at a phase wrap.
// Define LO_NCO_DITHER_EN to add an 8-bit LFSR dither into the phase bits just below the 6-bit quantiser.
module lo_nco_quad #(
    parameter int unsigned       ACC_W   = 16,
    parameter logic [ACC_W-1:0]  FTW_RST = ACC_W'(16'h0400),
    parameter int unsigned       ZW      = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             mode,
    input  logic [ACC_W-1:0] phase_off,
    input  logic [ACC_W-1:0] ftw_data,
    input  logic             ftw_valid,
    output logic             ftw_ready,
    output logic             sin_out,
    output logic             cos_out,
    output logic             sin_zero,
    output logic             cos_zero,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
    logic [ACC_W-1:0] pend_word_q, pend_word_d;
    logic             pend_q, pend_d;
    logic             sin_q, sin_d;
    logic             cos_q, cos_d;
    logic             sin_zero_q, sin_zero_d;
    logic             cos_zero_q, cos_zero_d;
    logic             wrap_q, wrap_d;

    logic [ACC_W-1:0] acc_sum;
    logic             carry;
    logic             accept;
    logic             apply;
    logic [5:0]       p6;
    logic [5:0]       q6;
    logic             phase_unused;

`ifdef LO_NCO_DITHER_EN
    logic [7:0]        lfsr_q, lfsr_d;
    logic [ACC_W+13:0] phase_ext;

    // Extend by 14 fractional bits so the dither lands on p[ACC_W-7:ACC_W-14] for any ACC_W >= 8.
    assign phase_ext    = {acc_q + phase_off, 14'd0} + ({{(ACC_W + 6){1'b0}}, lfsr_q} << ACC_W);
    assign p6           = phase_ext[ACC_W+13 -: 6];
    assign phase_unused = ^phase_ext[ACC_W+7:0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [ACC_W-1:0] phase;

    assign phase        = acc_q + phase_off;
    assign p6           = phase[ACC_W-1 -: 6];
    assign phase_unused = ^phase[ACC_W-7:0];
`endif

    // cos is sin advanced by a quarter cycle, so its window index trails by 16.
    assign q6 = p6 - 6'd16;

    function automatic logic in_zero_win(input logic [5:0] x);
        in_zero_win = (x >= 6'(64 - ZW)) || (x < 6'(ZW)) ||
                      ((x >= 6'(32 - ZW)) && (x < 6'(32 + ZW)));
    endfunction

    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ftw_act_q};
        accept = ftw_valid && !pend_q;
        // A zero tuning word never carries, so it must not wait for a wrap.
        apply  = en && pend_q && (carry || (ftw_act_q == '0));

        acc_d       = en ? acc_sum : acc_q;
        ftw_act_d   = apply ? pend_word_q : ftw_act_q;
        pend_word_d = accept ? ftw_data : pend_word_q;
        pend_d      = pend_q;
        if (accept) begin
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end

        sin_d      = sin_q;
        cos_d      = cos_q;
        sin_zero_d = sin_zero_q;
        cos_zero_d = cos_zero_q;
        if (en) begin
            sin_d      = ~p6[5];
            cos_d      = ~(p6[5] ^ p6[4]);
            sin_zero_d = mode && in_zero_win(p6);
            cos_zero_d = mode && in_zero_win(q6);
        end
        wrap_d = en && carry;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            acc_q       <= '0;
            ftw_act_q   <= FTW_RST;
            pend_word_q <= '0;
            pend_q      <= 1'b0;
            sin_q       <= 1'b0;
            cos_q       <= 1'b0;
            sin_zero_q  <= 1'b0;
            cos_zero_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ftw_act_q   <= ftw_act_d;
            pend_word_q <= pend_word_d;
            pend_q      <= pend_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            sin_zero_q  <= sin_zero_d;
            cos_zero_q  <= cos_zero_d;
            wrap_q      <= wrap_d;
        end
    end

    assign ftw_ready = !pend_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign sin_zero  = sin_zero_q;
    assign cos_zero  = cos_zero_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_lo_nco_quad.sv
// Bench for lo_nco_quad: the driver pushes expected output vectors per clock; a monitor pops and compares.
`timescale 1ns/1ps
module tb_lo_nco_quad;

    logic        clk       = 1'b0;
    logic        rstb      = 1'b1;
    logic        en        = 1'b0;
    logic        mode      = 1'b0;
    logic [15:0] phase_off = 16'h0000;
    logic [15:0] ftw_data  = 16'h0000;
    logic        ftw_valid = 1'b0;
    logic        ftw_ready;
    logic        sin_out;
    logic        cos_out;
    logic        sin_zero;
    logic        cos_zero;
    logic        wrap;

    always #5 clk = ~clk;

    lo_nco_quad #(
        .ACC_W  (16),
        .FTW_RST(16'h0400),
        .ZW     (5)
    ) dut (
        .clk      (clk),
        .rstb     (rstb),
        .en       (en),
        .mode     (mode),
        .phase_off(phase_off),
        .ftw_data (ftw_data),
        .ftw_valid(ftw_valid),
        .ftw_ready(ftw_ready),
        .sin_out  (sin_out),
        .cos_out  (cos_out),
        .sin_zero (sin_zero),
        .cos_zero (cos_zero),
        .wrap     (wrap)
    );

    // v = {sin, cos, sin_zero, cos_zero, wrap, ftw_ready}
    typedef struct packed {
        logic [31:0] sec;
        logic [5:0]  v;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          sec   = 0;

    logic [15:0] m_acc  = 16'h0000;
    logic [15:0] m_ftw  = 16'h0400;
    logic [15:0] m_pw   = 16'h0000;
    logic        m_pend = 1'b0;
    logic [3:0]  m_out  = 4'b0000;

    // Zero windows for ZW=5 written out by hand: p6 59..63, 0..4 and 27..36.
    function automatic logic in_win(input logic [5:0] x);
        return (x >= 6'd59) || (x <= 6'd4) || ((x >= 6'd27) && (x <= 6'd36));
    endfunction

    task automatic chk_now(input string name, input logic [5:0] want);
        logic [5:0] act;
        act = {sin_out, cos_out, sin_zero, cos_zero, wrap, ftw_ready};
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b (sin cos szero czero wrap rdy)", name, act, want);
        end
    endtask

    // Called just after a negedge with inputs settled: predicts the outputs after the next posedge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t        e;
            logic [15:0] p;
            logic [15:0] sum;
            logic [5:0]  p6;
            logic        c;
            logic        acc_take;
            logic        apl;
            e.sec = 32'(sec);
            if (!rstb) begin
                m_acc  = 16'h0000;
                m_ftw  = 16'h0400;
                m_pend = 1'b0;
                m_out  = 4'b0000;
                e.v    = 6'b000001;
            end else begin
                {c, sum} = {1'b0, m_acc} + {1'b0, m_ftw};
                if (en) begin
                    p     = m_acc + phase_off;
                    p6    = p[15:10];
                    m_out = {~p[15], ~(p[15] ^ p[14]), mode & in_win(p6), mode & in_win(p6 - 6'd16)};
                end
                acc_take = ftw_valid && !m_pend;
                apl      = en && m_pend && (c || (m_ftw == 16'h0000));
                if (en) m_acc = sum;
                if (apl) begin
                    m_ftw  = m_pw;
                    m_pend = 1'b0;
                end
                if (acc_take) begin
                    m_pw   = ftw_data;
                    m_pend = 1'b1;
                end
                e.v = {m_out, en & c, ~m_pend};
            end
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {sin_out, cos_out, sin_zero, cos_zero, wrap, ftw_ready};
                n_chk++;
                if (act !== e.v) begin
                    n_err++;
                    $display("FAIL out sec%0d t=%0t: got %b want %b (sin cos szero czero wrap rdy)",
                             e.sec, $time, act, e.v);
                end
            end
        end
    end

    initial begin : driver
        // Async reset from a defined high level so the negedge is seen.
        #1 rstb = 1'b0;
        #2 chk_now("reset_async", 6'b000001);
        @(negedge clk);
        step(2);
        rstb = 1'b1;

        // Held with en=0 straight out of reset.
        step(2);

        // Square quadrature, 64-cycle period.
        sec = 1;
        en  = 1'b1;
        step(130);

        // Three-level harmonic reject.
        sec  = 2;
        mode = 1'b1;
        step(130);

        // Handshake mid-period; the second word is offered while not ready and must be ignored.
        sec  = 3;
        mode = 1'b0;
        step(10);
        ftw_data  = 16'h1000;
        ftw_valid = 1'b1;
        step(1);
        ftw_data  = 16'h2000;
        step(3);
        ftw_valid = 1'b0;
        step(110);

        // Stop the oscillator, then restart it without needing a wrap.
        sec       = 4;
        ftw_data  = 16'h0000;
        ftw_valid = 1'b1;
        step(1);
        ftw_valid = 1'b0;
        step(30);
        ftw_data  = 16'h0800;
        ftw_valid = 1'b1;
        step(1);
        ftw_valid = 1'b0;
        step(70);

        // en low for 7 cycles mid-period.
        sec = 5;
        step(5);
        en = 1'b0;
        step(7);
        en = 1'b1;
        step(20);

        // Quarter-cycle phase offset.
        sec       = 6;
        phase_off = 16'h4000;
        step(40);
        phase_off = 16'h0000;
        step(4);

        // Reset while a word is pending: it must be discarded.
        sec       = 7;
        ftw_data  = 16'h1000;
        ftw_valid = 1'b1;
        step(1);
        ftw_valid = 1'b0;
        step(3);
        #2 rstb = 1'b0;
        #1 chk_now("reset_mid", 6'b000001);
        step(2);
        rstb = 1'b1;
        step(140);

        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
